mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single memoryController CPU port between instruction fetch (F, read-only) and the load/store unit (D).
//  Arbitrates round-robin and sequences one transaction at a time. Drives the load/store strobes, waits for read data
//  with a timeout and returns a registered response to the winner. Rejects misaligned or illegal D requests before any RAM access.
// PARAMETERS
//  DATA_WIDTH      `DATA_WIDTH (32)  data/address width; the block is only defined for 32
//  TIMEOUT_CYCLES  64                WAIT cycles without mc_read_valid before an error response; must be >= 2
// PORTS
//  clk               in   1   single clock; all state on posedge
//  reset             in   1   asynchronous, active-low (0 = in reset)
//  f_req             in   1   fetch request; held with f_addr until f_ready
//  f_addr            in   32  fetch byte address; word access, sign handling unused
//  f_ready           out  1   request accepted (1-cycle pulse)
//  f_rsp_valid       out  1   response pulse
//  f_rsp_data        out  32  read word
//  f_rsp_err         out  1   misaligned or timeout
//  d_req             in   1   data request; held with fields until d_ready
//  d_addr            in   32  byte address
//  d_wdata           in   32  store data (right-aligned)
//  d_length          in   2   0 byte, 1 half, 3 word; 2 illegal
//  d_store           in   1   1 store, 0 load
//  d_unsigned        in   1   zero-extend load
//  d_ready           out  1   request accepted (1-cycle pulse)
//  d_rsp_valid       out  1   response pulse (loads and stores)
//  d_rsp_data        out  32  load data; 0 for stores/errors
//  d_rsp_err         out  1   illegal length, misaligned or timeout
//  mc_address        out  32  to memoryController addressIn
//  mc_write_data     out  32  to dataWriteIn
//  mc_length         out  2   to length
//  mc_store          out  1   to storeIn
//  mc_load           out  1   to loadIn
//  mc_load_unsigned  out  1   to loadUnsigned
//  mc_read_data      in   32  from dataReadOut
//  mc_read_valid     in   1   from dataReadValid
//  busy              out  1   state != IDLE
// BEHAVIOUR
//  Reset: state IDLE, last_grant=F (D wins the first tie), timeout counter 0, every output 0.
//  Reset asserted mid-transaction: immediate return to IDLE; strobes drop asynchronously; no response issued.
//  IDLE:
//   - Pick a winner: if only one port requests, it wins; if both, the one not in last_grant.
//   - x_ready is combinational and high this cycle only. On the edge: register mc_* fields and grant; update last_grant.
//   - F fields: length=3, unsigned=0, store=0.
//   - Error check: d_length==2, word with addr[1:0]!=0, half with addr[0]=1, or F addr[1:0]!=0.
//     An error goes to RESP with err=1 and no strobe.
//   - Otherwise go to ISSUE.
//  ISSUE (1 cycle):
//   - mc_store or mc_load high for exactly this cycle.
//   - A store goes to RESP.
//   - A load with mc_read_valid this cycle captures data and goes to RESP; otherwise it goes to WAIT.
//  WAIT:
//   - The counter increments each cycle.
//   - mc_read_valid: capture mc_read_data, then go to RESP.
//   - Counter == TIMEOUT_CYCLES-1 without valid: go to RESP with err=1 and data 0.
//   - Simultaneous valid and timeout: the valid wins.
//  RESP (1 cycle): the winner's rsp_valid=1 with registered data/err; clear the counter; go to IDLE. The other port's rsp stays 0.
//  mc_address/data/length/unsigned are held stable from ISSUE through RESP. mc_read_valid outside ISSUE/WAIT is ignored.
//  Latency: store 3 cycles req->rsp_valid; load 3 + RAM wait; error 2. A new grant is not made in a RESP cycle.
//  No arithmetic beyond the counter, which has width $clog2(TIMEOUT_CYCLES) and never wraps.
// STRUCTURE
//  Shared package/include: globalVariables.v supplies `DATA_WIDTH; add `LEN_BYTE=0, `LEN_HALF=1, `LEN_WORD=3
//  and a 2-bit state encoding (IDLE=0, ISSUE=1, WAIT=2, RESP=3).
//  One sub-module, rr_arbiter2: req[1:0], last -> grant[1:0] one-hot, purely combinational.
//  The FSM, error check and counter live in the top.
// TESTING
//  1. Lone F req addr 0x100; RAM returns 0xDEADBEEF 2 cycles after mc_load -> f_ready@t0, f_rsp_valid data 0xDEADBEEF, err 0.
//  2. F and D both request in the same cycle after reset -> D granted first, then F.
//     Hold both requesting -> grants alternate D,F,D,F.
//  3. D store byte addr 0x203 data 0xAB -> mc_store pulse 1 cycle with mc_length 0.
//     d_rsp_valid 2 cycles later, data 0, err 0.
//  4. D word load addr 0x102; D length 2 -> each gives d_rsp_err=1 two cycles after d_ready; mc_load/mc_store never pulse.
//  5. D load with mc_read_valid never asserted -> d_rsp_err=1 exactly TIMEOUT_CYCLES cycles after WAIT entry.
//     Valid on the final count cycle -> data returned, err 0.
//  6. reset low during WAIT -> busy=0 and mc_load=0 immediately; the response after reset release does not appear.
//     The next request completes normally.

Source files
------------

// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the fetch / load-store memory port arbiter:
// length codes, FSM state encoding and the D-side legality check.
package mem_port_arbiter_pkg;

  localparam int MPA_DW = 32;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_ILL  = 2'd2;
  localparam logic [1:0] LEN_WORD = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2,
    S_RESP  = 2'd3
  } mpa_state_e;

  function automatic logic d_bad(
    input logic [1:0] len,
    input logic [1:0] a
  );
    d_bad = (len == LEN_ILL)
          | ((len == LEN_WORD) & (a != 2'b00))
          | ((len == LEN_HALF) & a[0]);
  endfunction

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin picker: req[0]=F, req[1]=D; last is the index
// of the previous winner. Purely combinational, one-hot grant.
module rr_arbiter2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);

  always_comb begin
    grant = 2'b00;
    unique case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memoryController CPU port between fetch (F) and load/store (D).
// Ports: f_* / d_* request+response per client, mc_* controller side, busy.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int DATA_WIDTH     = MPA_DW,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  f_req,
  input  logic [DATA_WIDTH-1:0] f_addr,
  output logic                  f_ready,
  output logic                  f_rsp_valid,
  output logic [DATA_WIDTH-1:0] f_rsp_data,
  output logic                  f_rsp_err,
  input  logic                  d_req,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [1:0]            d_length,
  input  logic                  d_store,
  input  logic                  d_unsigned,
  output logic                  d_ready,
  output logic                  d_rsp_valid,
  output logic [DATA_WIDTH-1:0] d_rsp_data,
  output logic                  d_rsp_err,
  output logic [DATA_WIDTH-1:0] mc_address,
  output logic [DATA_WIDTH-1:0] mc_write_data,
  output logic [1:0]            mc_length,
  output logic                  mc_store,
  output logic                  mc_load,
  output logic                  mc_load_unsigned,
  input  logic [DATA_WIDTH-1:0] mc_read_data,
  input  logic                  mc_read_valid,
  output logic                  busy
);

  localparam int CW = $clog2(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

  mpa_state_e            state_q;
  logic                  last_q;
  logic                  win_d_q;
  logic                  is_st_q;
  logic                  err_q;
  logic [CW-1:0]         cnt_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic [1:0] grant;
  logic       pick_d;
  logic       win;
  logic       bad;

  rr_arbiter2 u_arb (
    .req   ({d_req, f_req}),
    .last  (last_q),
    .grant (grant)
  );

  assign pick_d = grant[1];
  assign win    = (state_q == S_IDLE) & (|grant);

  // Ready is gated by reset so every output is low while held in reset.
  assign f_ready = win & grant[0] & reset;
  assign d_ready = win & grant[1] & reset;

  assign bad = pick_d ? d_bad(d_length, d_addr[1:0])
                      : (f_addr[1:0] != 2'b00);

  assign busy = (state_q != S_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q          <= S_IDLE;
      last_q           <= 1'b0;
      win_d_q          <= 1'b0;
      is_st_q          <= 1'b0;
      err_q            <= 1'b0;
      cnt_q            <= '0;
      rdata_q          <= '0;
      mc_address       <= '0;
      mc_write_data    <= '0;
      mc_length        <= 2'b00;
      mc_store         <= 1'b0;
      mc_load          <= 1'b0;
      mc_load_unsigned <= 1'b0;
      f_rsp_valid      <= 1'b0;
      f_rsp_data       <= '0;
      f_rsp_err        <= 1'b0;
      d_rsp_valid      <= 1'b0;
      d_rsp_data       <= '0;
      d_rsp_err        <= 1'b0;
    end else begin
      f_rsp_valid <= 1'b0;
      f_rsp_data  <= '0;
      f_rsp_err   <= 1'b0;
      d_rsp_valid <= 1'b0;
      d_rsp_data  <= '0;
      d_rsp_err   <= 1'b0;
      mc_store    <= 1'b0;
      mc_load     <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (win) begin
            last_q           <= pick_d;
            win_d_q          <= pick_d;
            mc_address       <= pick_d ? d_addr : f_addr;
            mc_write_data    <= pick_d ? d_wdata : '0;
            mc_length        <= pick_d ? d_length : LEN_WORD;
            mc_load_unsigned <= pick_d & d_unsigned;
            is_st_q          <= pick_d & d_store;
            rdata_q          <= '0;
            err_q            <= bad;
            // Rejected requests never touch the RAM.
            mc_store         <= ~bad & pick_d & d_store;
            mc_load          <= ~bad & ~(pick_d & d_store);
            state_q          <= bad ? S_RESP : S_ISSUE;
          end
        end
        S_ISSUE: begin
          if (is_st_q) begin
            state_q <= S_RESP;
          end else if (mc_read_valid) begin
            rdata_q <= mc_read_data;
            state_q <= S_RESP;
          end else begin
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          // Data on the final count cycle beats the timeout.
          if (mc_read_valid) begin
            rdata_q <= mc_read_data;
            state_q <= S_RESP;
          end else if (cnt_q == CNT_LAST) begin
            err_q   <= 1'b1;
            state_q <= S_RESP;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        S_RESP: begin
          cnt_q   <= '0;
          state_q <= S_IDLE;
          if (win_d_q) begin
            d_rsp_valid <= 1'b1;
            d_rsp_data  <= rdata_q;
            d_rsp_err   <= err_q;
          end else begin
            f_rsp_valid <= 1'b1;
            f_rsp_data  <= rdata_q;
            f_rsp_err   <= err_q;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a
// transaction-level reference model of latency, data and errors.
module tb_mem_port_arbiter;

  localparam int T = 64;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        f_req = 1'b0;
  logic [31:0] f_addr = '0;
  logic        f_ready;
  logic        f_rsp_valid;
  logic [31:0] f_rsp_data;
  logic        f_rsp_err;
  logic        d_req = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [1:0]  d_length = '0;
  logic        d_store = 1'b0;
  logic        d_unsigned = 1'b0;
  logic        d_ready;
  logic        d_rsp_valid;
  logic [31:0] d_rsp_data;
  logic        d_rsp_err;
  logic [31:0] mc_address;
  logic [31:0] mc_write_data;
  logic [1:0]  mc_length;
  logic        mc_store;
  logic        mc_load;
  logic        mc_load_unsigned;
  logic [31:0] mc_read_data = '0;
  logic        mc_read_valid = 1'b0;
  logic        busy;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .DATA_WIDTH     (32),
    .TIMEOUT_CYCLES (T)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .f_req            (f_req),
    .f_addr           (f_addr),
    .f_ready          (f_ready),
    .f_rsp_valid      (f_rsp_valid),
    .f_rsp_data       (f_rsp_data),
    .f_rsp_err        (f_rsp_err),
    .d_req            (d_req),
    .d_addr           (d_addr),
    .d_wdata          (d_wdata),
    .d_length         (d_length),
    .d_store          (d_store),
    .d_unsigned       (d_unsigned),
    .d_ready          (d_ready),
    .d_rsp_valid      (d_rsp_valid),
    .d_rsp_data       (d_rsp_data),
    .d_rsp_err        (d_rsp_err),
    .mc_address       (mc_address),
    .mc_write_data    (mc_write_data),
    .mc_length        (mc_length),
    .mc_store         (mc_store),
    .mc_load          (mc_load),
    .mc_load_unsigned (mc_load_unsigned),
    .mc_read_data     (mc_read_data),
    .mc_read_valid    (mc_read_valid),
    .busy             (busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: alignment by access size in bytes,
  // latency counted in cycles from the accepting cycle.
  function automatic void model(
    input  bit          is_d,
    input  logic [31:0] a,
    input  logic [1:0]  len,
    input  bit          st,
    input  bit          uns,
    input  int          dly,
    input  logic [31:0] rd,
    output bit          rej,
    output bit          err,
    output bit          ld,
    output bit          sb,
    output int          lat,
    output logic [31:0] data,
    output logic [1:0]  elen,
    output bit          euns
  );
    int  n;
    bit  st_e;
    elen = is_d ? len : 2'd3;
    euns = is_d && uns;
    st_e = is_d && st;
    n = (elen == 2'd0) ? 1 : (elen == 2'd1) ? 2 : (elen == 2'd3) ? 4 : 0;
    rej = (n == 0) ? 1'b1 : ((a % n) != 0);
    ld = !rej && !st_e;
    sb = !rej && st_e;
    if (rej) begin
      err = 1; lat = 2; data = 0;
    end else if (st_e) begin
      err = 0; lat = 3; data = 0;
    end else if (dly <= T) begin
      err = 0; lat = 3 + dly; data = rd;
    end else begin
      err = 1; lat = T + 3; data = 0;
    end
  endfunction

  task automatic scramble();
    f_addr     = $urandom;
    d_addr     = $urandom;
    d_wdata    = $urandom;
    d_length   = 2'($urandom_range(0, 3));
    d_store    = 1'($urandom_range(0, 1));
    d_unsigned = 1'($urandom_range(0, 1));
  endtask

  // dly: cycles after the mc_load pulse at which the RAM answers.
  task automatic run_txn(input bit is_d, input logic [31:0] a,
                         input logic [31:0] wd, input logic [1:0] len,
                         input bit st, input bit uns, input int dly,
                         input logic [31:0] rd);
    bit          rej, err, ld, sb, euns;
    int          lat;
    logic [31:0] data;
    logic [1:0]  elen;
    model(is_d, a, len, st, uns, dly, rd,
          rej, err, ld, sb, lat, data, elen, euns);
    @(posedge clk); #1;
    if (is_d) begin
      d_req = 1; d_addr = a; d_wdata = wd;
      d_length = len; d_store = st; d_unsigned = uns;
    end else begin
      f_req = 1; f_addr = a;
    end
    @(negedge clk);
    chk("ready", {f_ready, d_ready}, is_d ? 2'b01 : 2'b10);
    chk("busy_at_req", busy, 0);
    for (int c = 1; c <= lat; c++) begin
      @(posedge clk); #1;
      f_req = 0;
      d_req = 0;
      scramble();
      mc_read_valid = ld && (c == 1 + dly);
      mc_read_data  = mc_read_valid ? rd : $urandom;
      @(negedge clk);
      chk("strobe", {mc_load, mc_store}, (c == 1) ? {ld, sb} : 2'b00);
      chk("busy", busy, c < lat);
      chk("rsp_valid", {f_rsp_valid, d_rsp_valid},
          (c == lat) ? (is_d ? 2'b01 : 2'b10) : 2'b00);
      if (!rej && c < lat) begin
        chk("mc_address", mc_address, a);
        chk("mc_length", mc_length, elen);
        chk("mc_unsigned", mc_load_unsigned, euns);
        if (is_d) chk("mc_wdata", mc_write_data, wd);
      end
      if (c == lat) begin
        chk("rsp_data", is_d ? d_rsp_data : f_rsp_data, data);
        chk("rsp_err", is_d ? d_rsp_err : f_rsp_err, err);
      end
    end
    mc_read_valid = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]  exp_g;
    logic [1:0]  exp_r;
    bit          r_d, r_st, r_uns;
    logic [31:0] r_a, r_wd, r_rd;
    logic [1:0]  r_len;
    int          r_dly, r_sel;

    // Reset: all outputs low even with both clients requesting.
    f_req = 1; d_req = 1;
    #12;
    chk("rst_ctrl", {f_ready, d_ready, f_rsp_valid, d_rsp_valid,
                     mc_load, mc_store, busy, mc_load_unsigned}, 8'h00);
    chk("rst_addr", mc_address, 0);
    chk("rst_len", mc_length, 0);
    f_req = 0; d_req = 0;
    @(negedge clk);
    reset = 1;

    // Tie after reset: D first, then alternate.
    @(posedge clk); #1;
    f_req = 1; f_addr = 32'h101;
    d_req = 1; d_addr = 32'h0; d_length = 2'd2; d_store = 0;
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) begin
        @(posedge clk); #1;
      end
      if (i == 7) begin
        f_req = 0; d_req = 0;
      end
      @(negedge clk);
      exp_g = (i < 7 && i % 2 == 0) ?
              (((i / 2) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      exp_r = (i >= 2 && i % 2 == 0) ?
              ((((i / 2) - 1) % 2 == 0) ? 2'b01 : 2'b10) : 2'b00;
      chk("tie_grant", {f_ready, d_ready}, exp_g);
      chk("tie_rsp", {f_rsp_valid, d_rsp_valid}, exp_r);
      chk("tie_err", {f_rsp_err, d_rsp_err}, exp_r);
      chk("tie_nostrobe", {mc_load, mc_store}, 2'b00);
    end

    // Lone fetch, RAM answers 2 cycles after mc_load.
    run_txn(0, 32'h100, 0, 0, 0, 0, 2, 32'hDEADBEEF);
    // Byte store at odd address.
    run_txn(1, 32'h203, 32'hAB, 2'd0, 1, 0, 0, 0);
    // Rejected requests.
    run_txn(1, 32'h102, 0, 2'd3, 0, 0, 0, 32'h1234);
    run_txn(1, 32'h100, 0, 2'd2, 0, 0, 0, 32'h1234);
    run_txn(1, 32'h101, 0, 2'd1, 1, 0, 0, 0);
    run_txn(0, 32'h102, 0, 0, 0, 0, 0, 32'h55);
    // Same-cycle load data, half-word unsigned load.
    run_txn(1, 32'h302, 0, 2'd1, 0, 1, 0, 32'h0000BEEF);
    // Timeout, and data on the final count cycle.
    run_txn(1, 32'h400, 0, 2'd3, 0, 0, 1000, 0);
    run_txn(1, 32'h404, 0, 2'd3, 0, 0, T, 32'hCAFEF00D);
    run_txn(0, 32'h408, 0, 0, 0, 0, T - 1, 32'h0BADCAFE);

    // Reset while the load strobe is high.
    @(posedge clk); #1;
    d_req = 1; d_addr = 32'h40; d_length = 2'd3; d_store = 0;
    @(posedge clk); #1;
    d_req = 0;
    chk("pre_rst_load", mc_load, 1);
    #2 reset = 0;
    #1;
    chk("rst_issue_load", mc_load, 0);
    chk("rst_issue_busy", busy, 0);
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_issue_norsp", {f_rsp_valid, d_rsp_valid, busy}, 3'b000);
    end

    // Reset during WAIT.
    @(posedge clk); #1;
    d_req = 1; d_addr = 32'h80; d_length = 2'd3; d_store = 0;
    @(posedge clk); #1;
    d_req = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_rst_busy", busy, 1);
    #2 reset = 0;
    #1;
    chk("rst_wait_busy", busy, 0);
    chk("rst_wait_load", mc_load, 0);
    @(negedge clk);
    reset = 1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      mc_read_valid = (i == 2);
      mc_read_data  = 32'h77777777;
      @(negedge clk);
      chk("rst_wait_norsp", {f_rsp_valid, d_rsp_valid, busy}, 3'b000);
    end
    mc_read_valid = 0;
    run_txn(1, 32'h80, 0, 2'd3, 0, 0, 1, 32'h13572468);

    // Randomized transactions.
    for (int k = 0; k < 40; k++) begin
      r_d   = ($urandom_range(0, 3) != 0);
      r_a   = $urandom & 32'h0000_0FFF;
      if ($urandom_range(0, 2) != 0) r_a[1:0] = 2'b00;
      r_len = 2'($urandom_range(0, 3));
      r_st  = 1'($urandom_range(0, 1));
      r_uns = 1'($urandom_range(0, 1));
      r_wd  = $urandom;
      r_rd  = $urandom;
      r_sel = $urandom_range(0, 9);
      r_dly = (r_sel < 8) ? $urandom_range(0, 5) :
              (r_sel == 8) ? T : T + 1;
      run_txn(r_d, r_a, r_wd, r_len, r_st, r_uns, r_dly, r_rd);
    end

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
